// File: rtl/stream_mux_pkg.sv
// Shared constants for the registered N-channel stream multiplexer.
// Arbitration mode encodings and default sizing.
package stream_mux_pkg;
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    localparam int DEF_N_CH = 4;
    localparam int DEF_W    = 8;
    localparam int DEF_CNTW = 16;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin search starting at ptr, or lowest index first.
// Zero latency; no state, so backpressure is handled by the caller.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int SELW = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    output logic [N_CH-1:0] gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    always_comb begin
        int              start;
        int              idx;
        logic [SELW-1:0] idx_s;
        gnt     = '0;
        gnt_idx = '0;
        any     = |req;
        idx     = 0;
        idx_s   = '0;
        start   = (mode == MODE_FIXED) ? 0 : int'(ptr);
        // Walk the search order backwards so the earliest requester is written last.
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx   = (start + k) % N_CH;
            idx_s = SELW'(idx);
            if (req[idx_s]) begin
                gnt_idx = idx_s;
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux: arbitrates inputs into one registered output stage, counts transfers.
// Latency 1 cycle from input handshake to out_valid; stalls hold the output and drop all in_ready.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_CH = DEF_N_CH,
    parameter  int W    = DEF_W,
    parameter  int CNTW = DEF_CNTW,
    localparam int SELW = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_sel,
    input  logic              out_ready,
    output logic [CNTW-1:0]   xfer_cnt
);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_sel_q, out_sel_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            load;
    logic            any;
    logic [N_CH-1:0] gnt;
    logic [SELW-1:0] gnt_idx;

    rr_arbiter #(.N_CH(N_CH), .SELW(SELW)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .mode    (mode),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign load     = !out_valid_q || out_ready;
    assign in_ready = (load && !reset) ? gnt : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        if (load) begin
            out_valid_d = any;
            if (any) begin
                out_data_d = in_data[int'(gnt_idx)*W +: W];
                out_sel_d  = gnt_idx;
                if (mode == MODE_RR) begin
                    ptr_d = (gnt_idx == SELW'(N_CH - 1)) ? '0 : gnt_idx + SELW'(1);
                end
            end
        end
        if (out_valid_q && out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: reference model predicts grants and queues words,
// a separate monitor checks every presented output word and the transfer counter.
module tb_stream_mux_rr;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int CNTW = 5;
    localparam int SELW = 2;
    localparam int MAXC = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            mode = 1'b0;
    logic [N-1:0]    in_valid = '0;
    logic [N*W-1:0]  in_data = '0;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_sel;
    logic            out_ready = 1'b1;
    logic [CNTW-1:0] xfer_cnt;

    int vectors = 0;
    int errors  = 0;

    logic [SELW+W-1:0] sbq[$];
    logic              m_valid = 1'b0;
    int                m_ptr = 0;
    int                m_cnt = 0;
    logic              was_rst = 1'b0;
    logic [N-1:0]      hs_vec = '0;

    stream_mux_rr #(.N_CH(N), .W(W), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who should be granted this cycle, and what the output register will hold.
    always @(negedge clk) begin
        int              g;
        logic            ld;
        logic [N-1:0]    exp_rdy;
        logic [SELW-1:0] ix;
        if (reset) begin
            check("in_ready_during_reset", 32'(in_ready), 32'd0);
            m_valid = 1'b0;
            m_ptr   = 0;
            sbq.delete();
            hs_vec  = '0;
            was_rst = 1'b1;
        end else begin
            if (was_rst) begin
                check("out_data_after_reset", 32'(out_data), 32'd0);
                check("out_sel_after_reset", 32'(out_sel), 32'd0);
                was_rst = 1'b0;
            end
            check("out_valid", 32'(out_valid), 32'(m_valid));
            ld = !m_valid || out_ready;
            g  = -1;
            for (int k = N - 1; k >= 0; k--) begin
                ix = mode ? SELW'(k) : SELW'((m_ptr + k) % N);
                if (in_valid[ix]) g = int'(ix);
            end
            exp_rdy = (ld && g >= 0) ? N'(1 << g) : '0;
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            hs_vec = exp_rdy;
            if (ld) begin
                if (g >= 0) begin
                    ix = SELW'(g);
                    sbq.push_back({ix, in_data[g*W +: W]});
                    m_valid = 1'b1;
                    if (!mode) m_ptr = (g + 1) % N;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: every presented word must match the oldest predicted word.
    always @(negedge clk) begin
        logic [SELW+W-1:0] f;
        if (reset) begin
            m_cnt = 0;
        end else begin
            check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    f = sbq[0];
                    check("out_data", 32'(out_data), 32'(f[W-1:0]));
                    check("out_sel", 32'(out_sel), 32'(f[SELW+W-1:W]));
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        if (m_cnt < MAXC) m_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        // Reset two cycles with every channel requesting.
        reset    = 1'b1;
        in_valid = 4'b1111;
        in_data  = 32'hA3A2A1A0;
        tick();
        tick();
        reset = 1'b0;

        // Round-robin fairness, then a 3-cycle stall while 0xA1 is held.
        tick();
        tick();
        check("rr_second_word", 32'(out_data), 32'hA1);
        check("rr_second_sel", 32'(out_sel), 32'd1);
        out_ready = 1'b0;
        repeat (3) tick();
        check("stall_hold_data", 32'(out_data), 32'hA1);
        out_ready = 1'b1;
        tick();
        check("after_stall_word", 32'(out_data), 32'hA2);
        repeat (4) tick();

        // Fixed priority with ch0 and ch2 requesting.
        mode     = 1'b1;
        in_valid = 4'b0101;
        in_data  = 32'h00120010;
        repeat (6) tick();

        // Wrap and sparse request in round-robin.
        mode     = 1'b0;
        in_valid = 4'b0001;
        tick();
        in_valid = 4'b1000;
        in_data  = 32'h33000000;
        tick();
        check("wrap_word", 32'(out_data), 32'h33);
        check("wrap_sel", 32'(out_sel), 32'd3);
        in_valid = 4'b1001;
        in_data  = 32'h33000030;
        tick();
        check("wrap_then_ch0", 32'(out_sel), 32'd0);
        in_valid = 4'b0000;
        tick();

        // Mid-stream reset with the output register full.
        in_valid  = 4'b1111;
        in_data   = 32'hB3B2B1B0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_xfer_cnt", 32'(xfer_cnt), 32'd0);
        out_ready = 1'b1;
        repeat (3) tick();

        // Randomized traffic honouring the hold-until-handshake contract.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(99) < 1);
            if ($urandom_range(99) < 4) mode = ~mode;
            out_ready = ($urandom_range(99) < 70);
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || hs_vec[i]) begin
                    in_valid[i]       = ($urandom_range(99) < 50);
                    in_data[i*W +: W] = W'($urandom);
                end
            end
            tick();
        end

        // Drain.
        reset     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_queue_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel registered stream multiplexer. It is the sequential successor of the team's 4-to-1 combinational mux.
- Each input channel carries W-bit data with a valid/ready handshake. One channel is granted per cycle, either round-robin or fixed-priority, and the winner is registered into a single output stage with backpressure.
- Sits between multiple producers and one shared consumer. Also keeps a saturating transfer counter.

Parameters:
- N_CH, 4, number of input channels (>=2)
- W, 8, data width per channel
- SELW, $clog2(N_CH), width of channel-index signals (derived, not overridden)
- CNTW, 16, width of the transfer counter

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- in_valid  input  N_CH  per-channel valid
- in_data  input  N_CH*W  channel i occupies bits [i*W +: W]
- in_ready  output  N_CH  per-channel accept, one-hot or zero
- out_valid  output  1  output register holds data
- out_data  output  W  registered data
- out_sel  output  SELW  index of the channel that produced out_data
- out_ready  input  1  consumer accept
- xfer_cnt  output  CNTW  number of output handshakes, saturating

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_sel=0, xfer_cnt=0, round-robin pointer ptr=0.
- in_ready is 0 for every channel whenever reset=1.
- Load enable: load = !out_valid | out_ready.
- Grant is combinational from in_valid, ptr and mode.
  - mode=0: the first asserted in_valid searching ptr, ptr+1, ..., wrapping modulo N_CH.
  - mode=1: the lowest asserted index.
- in_ready[g] = load & in_valid[g] for the granted channel g only. in_ready is never multi-hot.
- Input handshake on channel g (in_valid[g] & in_ready[g]), registered on the next edge:
  - out_data <= in_data[g]; out_sel <= g; out_valid <= 1.
  - mode=0: ptr <= (g+1) mod N_CH, wrapping at N_CH-1 -> 0.
  - mode=1: ptr unchanged.
- Load with no valid input: out_valid <= 0 if out_ready consumed the current word. out_data and out_sel hold their values.
- Stall (out_valid=1, out_ready=0): out_data and out_sel are held stable, and in_ready is all zero.
- Throughput and latency:
  - Simultaneous consume and refill in one cycle is permitted, giving one word per cycle.
  - Latency from input handshake to out_valid is 1 cycle.
- xfer_cnt increments on each out_valid & out_ready and saturates at 2^CNTW-1.
- A mode change takes effect on the next arbitration. ptr is retained across mode changes.
- Reset asserted mid-stream: the word in the output register is discarded (out_valid=0 next edge). No in_ready is asserted in the reset cycle.
- Upstream contract: producers keep in_valid and in_data stable until their handshake. The block does not check this.

Decomposition:
- Package stream_mux_pkg holds:
  - MODE_RR=1'b0 and MODE_FIXED=1'b1 constants
  - default N_CH/W/CNTW constants
- One sub-module, rr_arbiter (parameter N_CH):
  - inputs: req[N_CH], ptr[SELW], mode
  - outputs: gnt one-hot, gnt_idx[SELW], any
  - purely combinational
- The top level owns ptr, the output register and the counter.

Test Plan (N_CH=4, W=8):
- Reset: reset=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0000, out_valid=0, xfer_cnt=0. After release, first grant is ch0.
- Round-robin fairness: mode=0, in_valid=1111, data ch0..3=0xA0..0xA3, out_ready=1.
  - out_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0 on consecutive cycles.
  - out_sel 0,1,2,3,0.
  - xfer_cnt increments by 1 each cycle.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 with out_data=0xA1.
  - out_data stays 0xA1, in_ready=0000, xfer_cnt is held.
  - With out_ready=1, 0xA2 appears next cycle.
- Fixed priority: mode=1, in_valid=0101 continuously -> only ch0 is ever granted, and in_ready[2] never asserts.
- Wrap and sparse request: mode=0 with ptr=1, only ch3 valid (0x33) -> grant ch3, out_data=0x33, ptr becomes 0. Then ch0 and ch3 valid -> ch0 wins.
- Mid-stream reset: reset=1 one cycle while out_valid=1 -> out_valid=0, ptr=0, xfer_cnt=0 next edge, in_ready=0000 during reset.
